// File: rtl/huffman_decoder_pkg.sv
// Shared definitions for the canonical Huffman decoder.
//   MAXBITS : maximum code length in bits (count-table length port is 4 bits wide)
//   NSYM    : symbol table depth
//   state_t : decoder FSM state encoding
package huff_pkg;

  localparam int unsigned MAXBITS = 15;
  localparam int unsigned NSYM    = 256;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EMIT,
    FIN,
    ERR
  } state_t;

endpackage

// File: rtl/huffman_decoder_if.sv
// Stream handshakes of the Huffman decoder.
//   in_data/in_valid/in_ready    : compressed 32-bit words, consumed MSB first
//   out_sym/out_valid/out_ready  : decoded symbol bytes
// master = the stream source/sink side, slave = the decoder.
interface huffman_decoder_if;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_sym;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_sym, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_sym, out_valid
  );

endinterface

// File: rtl/huffman_decoder_bit_shifter.sv
// Module huff_bit_shifter: holds the current 32-bit compressed word and
// presents its next unconsumed bit on o_bit.
//   clk, reset   : clock, synchronous active-high reset
//   i_load       : load i_word, bits_left = 32
//   i_shift      : consume one bit (ignored when no bits remain)
//   o_bit        : current MSB
//   o_bits_left  : unconsumed bits in the word (0..32)
module huff_bit_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_shift,
  input  logic [31:0] i_word,
  output logic        o_bit,
  output logic [5:0]  o_bits_left
);

  logic [31:0] r_word;
  logic [5:0]  r_bits_left;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word      <= '0;
      r_bits_left <= '0;
    end else if (i_load) begin
      r_word      <= i_word;
      r_bits_left <= 6'd32;
    end else if (i_shift && (r_bits_left != 6'd0)) begin
      r_word      <= {r_word[30:0], 1'b0};
      r_bits_left <= r_bits_left - 6'd1;
    end
  end

  assign o_bit       = r_word[31];
  assign o_bits_left = r_bits_left;

endmodule

// File: rtl/huffman_decoder.sv
// Canonical Huffman decoder, one code bit per cycle.
// Tables (count per code length, symbols in canonical order) are written in
// IDLE; start decodes total_syms symbols from a stream of 32-bit words.
//   clk, reset          : clock, synchronous active-high reset
//   cnt_wr/len/val      : count-table write (length 1..MAXBITS)
//   sym_wr/addr/val     : symbol-table write
//   start, total_syms   : begin a decode of total_syms symbols
//   s (slave modport)   : input word stream and output symbol stream
//   busy, done, error   : status; done pulses once after the last symbol
//   sym_count           : symbols emitted (tied to 0 unless HUFFDEC_STATS_EN)
// Optional feature macro: HUFFDEC_STATS_EN
module huffman_decoder #(
  parameter int unsigned MAXBITS = huff_pkg::MAXBITS,
  parameter int unsigned NSYM    = huff_pkg::NSYM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_wr,
  input  logic [3:0]        cnt_len,
  input  logic [8:0]        cnt_val,
  input  logic              sym_wr,
  input  logic [7:0]        sym_addr,
  input  logic [7:0]        sym_val,
  input  logic              start,
  input  logic [15:0]       total_syms,
  huffman_decoder_if.slave  s,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       sym_count
);

  import huff_pkg::*;

  localparam int unsigned AW = (NSYM > 1) ? $clog2(NSYM) : 1;

  state_t      r_state;
  logic [8:0]  r_cnt_tab [0:15];
  logic [7:0]  r_sym_tab [0:NSYM-1];
  logic [15:0] r_code, r_first, r_idx, r_total, r_nsym;
  logic [3:0]  r_len;
  logic        r_in_ready, r_out_valid, r_busy, r_done, r_error;
  logic [7:0]  r_out_sym;

  logic        w_bit;
  logic [5:0]  w_bits_left;
  logic [15:0] w_code, w_cnt, w_off, w_sym_idx, w_nsym_inc;
  logic [3:0]  w_len;
  logic        w_hit, w_in_hs, w_out_hs;
  logic [AW-1:0] w_waddr, w_raddr;

  huff_bit_shifter u_shifter (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_in_hs),
    .i_shift     (r_state == DECODE),
    .i_word      (s.in_data),
    .o_bit       (w_bit),
    .o_bits_left (w_bits_left)
  );

  // One step of the canonical walk for the bit currently at the shifter MSB.
  assign w_code     = r_code | {15'd0, w_bit};
  assign w_len      = r_len + 4'd1;
  assign w_cnt      = {7'd0, r_cnt_tab[w_len]};
  assign w_off      = w_code - r_first;
  assign w_hit      = (w_off < w_cnt);
  assign w_sym_idx  = r_idx + w_off;
  assign w_raddr    = AW'(w_sym_idx);
  assign w_waddr    = AW'(sym_addr);
  assign w_in_hs    = (r_state == FETCH) && s.in_valid && r_in_ready;
  assign w_out_hs   = (r_state == EMIT) && r_out_valid && s.out_ready;
  assign w_nsym_inc = r_nsym + 16'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 16; i++) r_cnt_tab[i] <= '0;
    end else if ((r_state == IDLE) && cnt_wr && (cnt_len != 4'd0) &&
                 (32'(cnt_len) <= MAXBITS)) begin
      r_cnt_tab[cnt_len] <= cnt_val;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && sym_wr && (32'(sym_addr) < NSYM))
      r_sym_tab[w_waddr] <= sym_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_code      <= '0;
      r_first     <= '0;
      r_idx       <= '0;
      r_len       <= '0;
      r_total     <= '0;
      r_nsym      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sym   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, ERR: begin
          if (start) begin
            r_error <= 1'b0;
            r_total <= total_syms;
            r_code  <= '0;
            r_first <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_nsym  <= '0;
            if (total_syms == 16'd0) begin
              r_state <= FIN;
              r_done  <= 1'b1;
            end else begin
              r_state    <= FETCH;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (w_in_hs) begin
            r_in_ready <= 1'b0;
            r_state    <= DECODE;
          end
        end
        DECODE: begin
          if (w_hit) begin
            r_out_sym   <= (32'(w_sym_idx) < NSYM) ? r_sym_tab[w_raddr] : 8'd0;
            r_out_valid <= 1'b1;
            r_state     <= EMIT;
          end else if (32'(w_len) >= MAXBITS) begin
            r_state <= ERR;
            r_error <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_idx   <= r_idx + w_cnt;
            r_first <= (r_first + w_cnt) << 1;
            r_code  <= w_code << 1;
            r_len   <= w_len;
            // Last bit of the word consumed mid-code: the partial code
            // registers carry over into the next word.
            if (w_bits_left == 6'd1) begin
              r_state    <= FETCH;
              r_in_ready <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_nsym      <= w_nsym_inc;
            r_code      <= '0;
            r_first     <= '0;
            r_idx       <= '0;
            r_len       <= '0;
            if (w_nsym_inc == r_total) begin
              r_state <= FIN;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_bits_left == 6'd0) begin
              r_state    <= FETCH;
              r_in_ready <= 1'b1;
            end else begin
              r_state <= DECODE;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s.in_ready  = r_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.out_sym   = r_out_sym;
  assign busy        = r_busy;
  assign done        = r_done;
  assign error       = r_error;

`ifdef HUFFDEC_STATS_EN
  assign sym_count = r_nsym;
`else
  assign sym_count = '0;
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: tests queue expected symbols, a
// negedge monitor pops and compares on every output handshake.
// Table: len1=1, len2=1, len3=2, symbols 0x41..0x44 (A=0, B=10, C=110, D=111).
module tb_huffman_decoder;

  logic        clk = 1'b0;
  logic        reset, cnt_wr, sym_wr, start;
  logic [3:0]  cnt_len;
  logic [8:0]  cnt_val;
  logic [7:0]  sym_addr, sym_val;
  logic [15:0] total_syms, sym_count;
  logic        busy, done, error;

  huffman_decoder_if bus ();

  huffman_decoder #(.MAXBITS(15), .NSYM(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .cnt_wr     (cnt_wr),
    .cnt_len    (cnt_len),
    .cnt_val    (cnt_val),
    .sym_wr     (sym_wr),
    .sym_addr   (sym_addr),
    .sym_val    (sym_val),
    .start      (start),
    .total_syms (total_syms),
    .s          (bus),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .sym_count  (sym_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         hs_count = 0;
  logic [7:0] exp_q[$];

`ifdef HUFFDEC_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_sym_unexpected: got 0x%0h, expected no symbol", bus.out_sym);
      end else begin
        chk("out_sym", {24'd0, bus.out_sym}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_table(input logic [8:0] c1, input logic [8:0] c2, input logic [8:0] c3);
    for (int l = 1; l <= 15; l++) begin
      cnt_wr  = 1'b1;
      cnt_len = 4'(l);
      cnt_val = (l == 1) ? c1 : (l == 2) ? c2 : (l == 3) ? c3 : 9'd0;
      tick();
    end
    cnt_wr = 1'b0;
    for (int a = 0; a < 4; a++) begin
      sym_wr   = 1'b1;
      sym_addr = 8'(a);
      sym_val  = 8'(8'h41 + a);
      tick();
    end
    sym_wr = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n);
    start      = 1'b1;
    total_syms = n;
    tick();
    start = 1'b0;
  endtask

  // Offer one word; returns just after the accepting edge (DUT then in DECODE).
  task automatic feed(input logic [31:0] w, input string name);
    bit ok = 1'b0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) tick();
    bus.in_valid = 1'b0;
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, {31'd0, seen}, 32'd1);
    if (seen) begin
      @(negedge clk);
      chk($sformatf("%s_one_cycle", name), {31'd0, done}, 32'd0);
    end
    tick();
  endtask

  task automatic push_basic();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h41);
  endtask

  task automatic run_basic(input string tag);
    bus.out_ready = 1'b1;
    push_basic();
    do_start(16'd5);
    feed(32'h5C00_0000, {tag, "_fetch"});
    // First code is 1 bit long: out_valid one cycle after DECODE entry.
    chk({tag, "_lat_decode"}, {31'd0, bus.out_valid}, 32'd0);
    tick();
    chk({tag, "_lat_emit"}, {31'd0, bus.out_valid}, 32'd1);
    wait_done({tag, "_done"});
    chk({tag, "_sym_count"}, {16'd0, sym_count}, STATS ? 32'd5 : 32'd0);
    chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    bit done_seen;
    reset = 1'b1; cnt_wr = 1'b0; sym_wr = 1'b0; start = 1'b0;
    cnt_len = '0; cnt_val = '0; sym_addr = '0; sym_val = '0; total_syms = '0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    do_reset();

    // Reset values
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_sym",   {24'd0, bus.out_sym},   32'd0);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    chk("rst_done",      {31'd0, done},          32'd0);
    chk("rst_error",     {31'd0, error},         32'd0);
    chk("rst_sym_count", {16'd0, sym_count},     32'd0);

    // Basic decode
    load_table(9'd1, 9'd1, 9'd2);
    run_basic("basic");

    // Zero-length decode: FIN right after start, no fetch
    do_start(16'd0);
    chk("zero_done",     {31'd0, done},         32'd1);
    chk("zero_in_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    chk("zero_done_low", {31'd0, done},         32'd0);
    chk("zero_in_ready2",{31'd0, bus.in_ready}, 32'd0);
    chk("zero_sym_count",{16'd0, sym_count},    32'd0);

    // Word span: 31 x A, then B split across the word boundary
    for (int i = 0; i < 31; i++) exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    bus.out_ready = 1'b1;
    do_start(16'd32);
    feed(32'h0000_0001, "span_word1");
    feed(32'h0000_0000, "span_word2");
    wait_done("span_done");
    chk("span_sym_count", {16'd0, sym_count}, STATS ? 32'd32 : 32'd0);
    chk("span_queue_empty", exp_q.size(), 32'd0);

    // Backpressure on the first symbol
    bus.out_ready = 1'b0;
    push_basic();
    do_start(16'd5);
    feed(32'h5C00_0000, "bp_fetch");
    begin
      bit v = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.out_valid === 1'b1) begin v = 1'b1; break; end
      end
      chk("bp_valid_rise", {31'd0, v}, 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp_sym_%0d", i),      {24'd0, bus.out_sym},   32'h41);
      chk($sformatf("bp_valid_%0d", i),    {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("bp_in_ready_%0d", i), {31'd0, bus.in_ready},  32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_done("bp_done");
    chk("bp_queue_empty", exp_q.size(), 32'd0);

    // Invalid code: empty count table
    do_reset();
    load_table(9'd0, 9'd0, 9'd0);
    bus.out_ready = 1'b1;
    do_start(16'd1);
    feed(32'hFFFF_FFFF, "err_fetch");
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("err_low_%0d", k), {31'd0, error}, 32'd0);
    end
    tick();
    chk("err_rise",      {31'd0, error},         32'd1);
    chk("err_busy",      {31'd0, busy},          32'd0);
    chk("err_in_ready",  {31'd0, bus.in_ready},  32'd0);
    tick(); tick(); tick();
    chk("err_held",      {31'd0, error},         32'd1);
    chk("err_no_valid",  {31'd0, bus.out_valid}, 32'd0);
    do_start(16'd0);
    chk("err_cleared",   {31'd0, error},         32'd0);
    tick();

    // Reset during the third symbol
    load_table(9'd1, 9'd1, 9'd2);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    hs_count = 0;
    bus.out_ready = 1'b1;
    do_start(16'd5);
    feed(32'h5C00_0000, "rmid_fetch");
    begin
      bit got2 = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (hs_count >= 2) begin got2 = 1'b1; break; end
        tick();
      end
      chk("rmid_two_syms", {31'd0, got2}, 32'd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_in_ready",  {31'd0, bus.in_ready},  32'd0);
    chk("rmid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rmid_out_sym",   {24'd0, bus.out_sym},   32'd0);
    chk("rmid_busy",      {31'd0, busy},          32'd0);
    chk("rmid_error",     {31'd0, error},         32'd0);
    chk("rmid_sym_count", {16'd0, sym_count},     32'd0);
    chk("rmid_queue_empty", exp_q.size(),         32'd0);
    done_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || bus.out_valid === 1'b1) done_seen = 1'b1;
    end
    chk("rmid_no_done", {31'd0, done_seen}, 32'd0);
    tick();
    load_table(9'd1, 9'd1, 9'd2);
    run_basic("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
